// File: rtl/traffic_intersection_ctrl_if.sv
// Signal bundle between the intersection controller and its environment.
// The slave side is the controller; the master side drives enable/requests.
interface traffic_intersection_ctrl_if;
    logic       enable;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk_ns;
    logic       walk_ew;
    logic       ped_pending_ns;
    logic       ped_pending_ew;
    logic [2:0] state_o;

    modport master (
        output enable, ped_req_ns, ped_req_ew,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  walk_ns, walk_ew,
        input  ped_pending_ns, ped_pending_ew,
        input  state_o
    );

    modport slave (
        input  enable, ped_req_ns, ped_req_ew,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output walk_ns, walk_ew,
        output ped_pending_ns, ped_pending_ew,
        output state_o
    );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Timed two-road intersection controller with pedestrian latches,
// early green termination, walk grants and a flashing maintenance mode.
module traffic_intersection_ctrl #(
    parameter int GREEN_TIME  = 20,
    parameter int MIN_GREEN   = 6,
    parameter int YELLOW_TIME = 4,
    parameter int ALLRED_TIME = 2,
    parameter int FLASH_HALF  = 5,
    parameter int CNT_W       = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    traffic_intersection_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5,
        FLASH = 3'd6,
        BAD   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] G_END = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] M_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] R_END = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] F_END = CNT_W'(FLASH_HALF - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic             flash_phase;
    logic             pend_ns;
    logic             pend_ew;
    logic             walk_ns_q;
    logic             walk_ew_q;
    logic             enter_ewg;
    logic             enter_nsg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AR_EW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            NS_G: begin
                if (timer == G_END || (pend_ns && timer >= M_END))
                    state_nxt = NS_Y;
            end
            NS_Y:  if (timer == Y_END) state_nxt = AR_NS;
            AR_NS: if (timer == R_END) state_nxt = EW_G;
            EW_G: begin
                if (timer == G_END || (pend_ew && timer >= M_END))
                    state_nxt = EW_Y;
            end
            EW_Y:  if (timer == Y_END) state_nxt = AR_EW;
            AR_EW: if (timer == R_END) state_nxt = NS_G;
            FLASH: state_nxt = AR_EW;
            default: state_nxt = AR_EW;
        endcase
        // Maintenance override wins everywhere except the illegal code
        if (!bus.enable && state != BAD)
            state_nxt = FLASH;
    end

    assign enter_ewg = (state_nxt == EW_G) && (state != EW_G);
    assign enter_nsg = (state_nxt == NS_G) && (state != NS_G);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            flash_phase <= 1'b0;
        end else begin
            if (state_nxt != state)
                timer <= '0;
            else if (state == FLASH && timer == F_END)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state_nxt != FLASH)
                flash_phase <= 1'b0;
            else if (state != FLASH)
                flash_phase <= 1'b1;
            else if (timer == F_END)
                flash_phase <= ~flash_phase;
        end
    end

    // A request on the clearing edge still counts for this green's walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ns   <= 1'b0;
            pend_ew   <= 1'b0;
            walk_ns_q <= 1'b0;
            walk_ew_q <= 1'b0;
        end else begin
            pend_ns <= bus.ped_req_ns | (pend_ns & ~enter_ewg);
            pend_ew <= bus.ped_req_ew | (pend_ew & ~enter_nsg);

            if (state_nxt != EW_G)
                walk_ns_q <= 1'b0;
            else if (enter_ewg)
                walk_ns_q <= pend_ns | bus.ped_req_ns;

            if (state_nxt != NS_G)
                walk_ew_q <= 1'b0;
            else if (enter_nsg)
                walk_ew_q <= pend_ew | bus.ped_req_ew;
        end
    end

    always_comb begin
        bus.ns_red    = 1'b0;
        bus.ns_yellow = 1'b0;
        bus.ns_green  = 1'b0;
        bus.ew_red    = 1'b0;
        bus.ew_yellow = 1'b0;
        bus.ew_green  = 1'b0;
        unique case (state)
            NS_G: begin
                bus.ns_green = 1'b1;
                bus.ew_red   = 1'b1;
            end
            NS_Y: begin
                bus.ns_yellow = 1'b1;
                bus.ew_red    = 1'b1;
            end
            EW_G: begin
                bus.ew_green = 1'b1;
                bus.ns_red   = 1'b1;
            end
            EW_Y: begin
                bus.ew_yellow = 1'b1;
                bus.ns_red    = 1'b1;
            end
            FLASH: begin
                bus.ns_red = flash_phase;
                bus.ew_red = flash_phase;
            end
            default: begin
                bus.ns_red = 1'b1;
                bus.ew_red = 1'b1;
            end
        endcase
    end

    assign bus.walk_ns        = walk_ns_q;
    assign bus.walk_ew        = walk_ew_q;
    assign bus.ped_pending_ns = pend_ns;
    assign bus.ped_pending_ew = pend_ew;
    assign bus.state_o        = state;

endmodule
